// File: rtl/sram_nios2_dbg_ocimem_arbiter_pkg.sv
// ============================================================================
// sram_nios2_dbg_ocimem_arbiter_pkg: shared types for the OCI memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_nios2_dbg_ocimem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C_WR  = 3'd1,
    C_RD  = 3'd2,
    C_RDW = 3'd3,
    J_WR  = 3'd4,
    J_RD  = 3'd5,
    J_RDW = 3'd6
  } state_e;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  localparam int JDO_ADDR_LSB = 26;
  localparam int JDO_DATA_LSB = 3;

endpackage

`default_nettype wire

// File: rtl/sram_nios2_dbg_ocimem_arbiter.sv
// ============================================================================
// sram_nios2_dbg_ocimem_arbiter: shares the debug memory between Avalon CPU
// port and JTAG host commands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_nios2_dbg_ocimem_arbiter
  import sram_nios2_dbg_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int JDO_W  = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_waitrequest,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byteen,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                jtag_busy,
  output logic                jtag_overrun
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic                pend_valid_q, pend_valid_d;
  cmd_e                pend_cmd_q, pend_cmd_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic                overrun_q, overrun_d;

  logic                w_wr_stb, w_rd_stb, w_cmd_stb, w_multi_stb;
  logic                w_jinc, w_pend_clr;

  logic                unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_DATA_LSB+DATA_W], jdo[JDO_DATA_LSB-1:0]};

  // Address load outranks write, write outranks read; losers count as overruns.
  assign w_wr_stb    = take_action_ocimem_b & ~take_action_ocimem_a;
  assign w_rd_stb    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_cmd_stb   = w_wr_stb | w_rd_stb;
  assign w_multi_stb = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                     | (take_action_ocimem_b & take_no_action_ocimem_a);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      jaddr_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CMD_RD;
      pend_data_q  <= '0;
      mon_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      jaddr_q      <= jaddr_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      pend_data_q  <= pend_data_d;
      mon_q        <= mon_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cpu_waitrequest = 1'b1;
    cpu_readdata    = '0;
    mem_addr        = cpu_address;
    mem_wdata       = cpu_writedata;
    mem_byteen      = '0;
    mem_wren        = 1'b0;
    mon_d           = mon_q;
    w_jinc          = 1'b0;
    w_pend_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid_q)   state_d = (pend_cmd_q == CMD_WR) ? J_WR : J_RD;
        else if (cpu_write) state_d = C_WR;
        else if (cpu_read)  state_d = C_RD;
      end
      C_WR: begin
        mem_wren        = 1'b1;
        mem_byteen      = cpu_byteenable;
        cpu_waitrequest = 1'b0;
        state_d         = IDLE;
      end
      C_RD: state_d = C_RDW;
      C_RDW: begin
        cpu_readdata    = mem_rdata;
        cpu_waitrequest = 1'b0;
        state_d         = IDLE;
      end
      J_WR: begin
        mem_addr   = jaddr_q;
        mem_wdata  = pend_data_q;
        mem_byteen = '1;
        mem_wren   = 1'b1;
        w_pend_clr = 1'b1;
        w_jinc     = 1'b1;
        state_d    = IDLE;
      end
      J_RD: begin
        mem_addr = jaddr_q;
        state_d  = J_RDW;
      end
      J_RDW: begin
        mem_addr   = jaddr_q;
        mon_d      = mem_rdata;
        w_pend_clr = 1'b1;
        w_jinc     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A strobe can never coincide with a clear: clears only happen while full.
  always_comb begin
    jaddr_d      = jaddr_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    pend_data_d  = pend_data_q;
    overrun_d    = overrun_q;
    if (take_action_ocimem_a)
      jaddr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
    else if (w_jinc)
      jaddr_d = jaddr_q + ADDR_W'(1);
    if (w_pend_clr)
      pend_valid_d = 1'b0;
    if (w_cmd_stb && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_cmd_d   = w_wr_stb ? CMD_WR : CMD_RD;
      if (w_wr_stb) pend_data_d = jdo[JDO_DATA_LSB +: DATA_W];
    end
    if (w_multi_stb || (w_cmd_stb && pend_valid_q))
      overrun_d = 1'b1;
  end

  assign MonDReg      = mon_q;
  assign jtag_overrun = overrun_q;
  assign jtag_busy    = pend_valid_q | (state_q == J_WR) | (state_q == J_RD) | (state_q == J_RDW);

endmodule

`default_nettype wire
